// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF challenge sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StMeasure = 3'd2,
    StSettle  = 3'd3,
    StSample  = 3'd4,
    StDone    = 3'd5
  } state_e;

  // Taps for x^8+x^6+x^5+x^4+1: feedback is c[7]^c[5]^c[4]^c[3].
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
  localparam logic [31:0] ENABLE_ALL    = 32'hFFFF_FFFF;
  localparam logic [7:0]  SEED_ZERO_SUB = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] c);
    return {c[6:0], ^(c & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_challenge_gen.sv
// Challenge register: loads the run seed or advances one Fibonacci LFSR step.
module lfsr_challenge_gen
  import puf_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] challenge
);

  logic [7:0] challenge_q, challenge_d;

  always_comb begin
    challenge_d = challenge_q;
    if (load) begin
      challenge_d = seed;
    end else if (step) begin
      challenge_d = lfsr_next(challenge_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      challenge_q <= 8'h00;
    end else begin
      challenge_q <= challenge_d;
    end
  end

  assign challenge = challenge_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences LFSR challenges through RO measurement windows and packs the
// synchronized arbiter bits into a response word with a valid/ready handoff.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned RESP_BITS     = 16,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           seed,
  output logic [7:0]           challenge,
  output logic [31:0]          enable,
  input  logic                 race_arbiter_out,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
);

  localparam int unsigned CntMax  = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES
                                                                    : SETTLE_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax) + 1;
  localparam int unsigned BitCntW = $clog2(RESP_BITS + 1);

  localparam logic [CntW-1:0]    WindowLoad = CntW'(WINDOW_CYCLES);
  localparam logic [CntW-1:0]    SettleLoad = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0]    CntOne     = CntW'(1);
  localparam logic [BitCntW-1:0] LastBit    = BitCntW'(RESP_BITS - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]           seed_q, seed_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [1:0]           sync_q;
  logic [RESP_BITS:0]   resp_shifted;
  logic                 lfsr_load, lfsr_step;

  // Shift through a one-wider vector so RESP_BITS == 1 needs no special case.
  assign resp_shifted = {resp_q, sync_q[1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    seed_d     = seed_q;
    resp_d     = resp_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    enable     = '0;
    resp_valid = 1'b0;
    busy       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d    = (seed == 8'h00) ? SEED_ZERO_SUB : seed;
          resp_d    = '0;
          bit_cnt_d = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (bit_cnt_q == '0) begin
          lfsr_load = 1'b1;
        end else begin
          lfsr_step = 1'b1;
        end
        cnt_d   = WindowLoad;
        state_d = StMeasure;
      end
      StMeasure: begin
        enable = ENABLE_ALL;
        if (cnt_q == CntOne) begin
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSettle: begin
        if (cnt_q == CntOne) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSample: begin
        resp_d    = resp_shifted[RESP_BITS-1:0];
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
        state_d   = (bit_cnt_q == LastBit) ? StDone : StLoad;
      end
      StDone: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      seed_q    <= SEED_ZERO_SUB;
      resp_q    <= '0;
      sync_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      seed_q    <= seed_d;
      resp_q    <= resp_d;
      sync_q    <= {sync_q[0], race_arbiter_out};
    end
  end

  lfsr_challenge_gen u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .load      (lfsr_load),
    .step      (lfsr_step),
    .seed      (seed_q),
    .challenge (challenge)
  );

  assign response = resp_q;

endmodule
